// File: rtl/ex_stage.sv
// Execute stage: single-cycle RV32I ALU plus iterative 32-step M-extension
// engine, feeding the EX/MEM pipeline register.
module ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ctrl_ex,
  input  logic [3:0]  alu_op,
  input  logic        alu_src,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] rd_ex,
  input  logic [31:0] pc4_ex,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] imm,
  output logic [4:0]  ctrl_mem,
  output logic [31:0] rd_mem,
  output logic [31:0] pc4_mem,
  output logic [31:0] alu_result,
  output logic [31:0] write_data1,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic        r_sa;
  logic        r_sb;
  logic        r_dz;

  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [4:0]  w_sh;

  assign w_b  = alu_src ? imm : read_data2;
  assign w_sh = w_b[4:0];

  always_comb begin
    w_alu = 32'd0;
    case (alu_op)
      4'd0:    w_alu = read_data1 + w_b;
      4'd1:    w_alu = read_data1 - w_b;
      4'd2:    w_alu = read_data1 << w_sh;
      4'd3:    w_alu = {31'd0, $signed(read_data1) < $signed(w_b)};
      4'd4:    w_alu = {31'd0, read_data1 < w_b};
      4'd5:    w_alu = read_data1 ^ w_b;
      4'd6:    w_alu = read_data1 >> w_sh;
      4'd7:    w_alu = $signed(read_data1) >>> w_sh;
      4'd8:    w_alu = read_data1 | w_b;
      4'd9:    w_alu = read_data1 & w_b;
      4'd10:   w_alu = w_b;
      default: w_alu = 32'd0;
    endcase
  end

  // MUL low word is sign-agnostic, so it shares the signed path
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_amag;
  logic [31:0] w_bmag;

  assign w_a_signed = ~(md_op[0] & (md_op != 3'd1));
  assign w_b_signed = (md_op == 3'd0) | (md_op == 3'd1) |
                      (md_op == 3'd4) | (md_op == 3'd6);
  assign w_sa   = read_data1[31] & w_a_signed;
  assign w_sb   = read_data2[31] & w_b_signed;
  assign w_amag = w_sa ? -read_data1 : read_data1;
  assign w_bmag = w_sb ? -read_data2 : read_data2;

  logic [32:0] w_madd;
  logic [32:0] w_dsh;
  logic [32:0] w_ddiff;
  logic        w_dok;

  assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_dsh   = {r_hi, r_lo[31]};
  assign w_ddiff = w_dsh - {1'b0, r_b};
  assign w_dok   = ~w_ddiff[32];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (md_en) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 5'd31) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign stall = reset_n &
                 (((r_state == S_IDLE) & md_en) | (r_state == S_BUSY));

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Multiply: shift-add into {hi,lo}. Divide: restoring, quotient in lo.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= 5'd0;
      r_op  <= 3'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_b   <= 32'd0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (md_en) begin
            r_cnt <= 5'd0;
            r_op  <= md_op;
            r_hi  <= 32'd0;
            r_lo  <= w_amag;
            r_b   <= w_bmag;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_dz  <= (read_data2 == 32'd0);
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_op[2]) begin
            r_hi <= w_dok ? w_ddiff[31:0] : w_dsh[31:0];
            r_lo <= {r_lo[30:0], w_dok};
          end else begin
            r_hi <= w_madd[32:1];
            r_lo <= {w_madd[0], r_lo[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

  logic [63:0] w_prod;
  logic [63:0] w_sprod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_md;

  assign w_prod  = {r_hi, r_lo};
  assign w_sprod = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_quo   = (r_sa ^ r_sb) ? -r_lo : r_lo;
  assign w_rem   = r_sa ? -r_hi : r_hi;

  // x/0 remainder falls out of the datapath as the dividend;
  // signed overflow also resolves naturally to 0x80000000 / 0
  always_comb begin
    w_md = 32'd0;
    case (r_op)
      3'd0:          w_md = w_sprod[31:0];
      3'd1,
      3'd2,
      3'd3:          w_md = w_sprod[63:32];
      3'd4,
      3'd5:          w_md = r_dz ? 32'hFFFF_FFFF : w_quo;
      default:       w_md = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_mem    <= 5'd0;
      rd_mem      <= 32'd0;
      pc4_mem     <= 32'd0;
      alu_result  <= 32'd0;
      write_data1 <= 32'd0;
    end else if (stall) begin
      ctrl_mem    <= 5'd0;
    end else begin
      ctrl_mem    <= ctrl_ex;
      rd_mem      <= rd_ex;
      pc4_mem     <= pc4_ex;
      alu_result  <= (r_state == S_DONE) ? w_md : w_alu;
      write_data1 <= read_data2;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic
// reference model of the RV32I ALU and M-extension semantics.
module tb_ex_stage;

  logic        clk;
  logic        reset_n;
  logic [4:0]  ctrl_ex;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        md_en;
  logic [2:0]  md_op;
  logic [31:0] rd_ex;
  logic [31:0] pc4_ex;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] imm;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem;
  logic [31:0] pc4_mem;
  logic [31:0] alu_result;
  logic [31:0] write_data1;
  logic        stall;

  int n_chk;
  int n_fail;

  ex_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl_ex     (ctrl_ex),
    .alu_op      (alu_op),
    .alu_src     (alu_src),
    .md_en       (md_en),
    .md_op       (md_op),
    .rd_ex       (rd_ex),
    .pc4_ex      (pc4_ex),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .imm         (imm),
    .ctrl_mem    (ctrl_mem),
    .rd_mem      (rd_mem),
    .pc4_mem     (pc4_mem),
    .alu_result  (alu_result),
    .write_data1 (write_data1),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int ia;
    int ib;
    int sh;
    ia = a;
    ib = b;
    sh = int'(b[4:0]);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return (ia < ib) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return ia >>> sh;
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    int ia;
    int ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    p  = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_alu(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic src,
                         input logic [4:0] c, input logic [31:0] exp);
    logic [31:0] rd;
    logic [31:0] pc;
    logic [31:0] d2;
    @(negedge clk);
    rd = $urandom;
    pc = $urandom;
    d2 = src ? $urandom : b;
    ctrl_ex    = c;
    rd_ex      = rd;
    pc4_ex     = pc;
    alu_op     = op;
    alu_src    = src;
    md_en      = 1'b0;
    md_op      = 3'($urandom);
    read_data1 = a;
    read_data2 = d2;
    imm        = src ? b : $urandom;
    #1;
    chk("alu_stall", stall, 0);
    @(posedge clk);
    #1;
    chk("alu_result", alu_result, exp);
    chk("alu_ctrl", ctrl_mem, c);
    chk("alu_rd_pc4_wd", {rd_mem, pc4_mem, write_data1},
        {rd, pc, d2});
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    logic [4:0]  c;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [31:0] prev_rd;
    int          n;
    bit          bad;
    @(negedge clk);
    c  = 5'($urandom);
    rd = $urandom;
    pc = $urandom;
    ctrl_ex    = c;
    rd_ex      = rd;
    pc4_ex     = pc;
    alu_op     = 4'($urandom);
    alu_src    = 1'($urandom);
    md_en      = 1'b1;
    md_op      = op;
    read_data1 = a;
    read_data2 = b;
    imm        = $urandom;
    prev_rd    = rd_mem;
    n   = 0;
    bad = 0;
    #1;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      if (ctrl_mem != 5'd0 || rd_mem != prev_rd) bad = 1;
    end
    chk("md_stall_cycles", n, 33);
    chk("md_bubble", bad, 0);
    @(posedge clk);
    #1;
    chk("md_result", alu_result, exp);
    chk("md_ctrl", ctrl_mem, c);
    chk("md_rd_pc4_wd", {rd_mem, pc4_mem, write_data1}, {rd, pc, b});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aop;
    logic [2:0]  mop;
    logic        src;
    logic [4:0]  c;
    n_chk  = 0;
    n_fail = 0;
    reset_n    = 1'b0;
    ctrl_ex    = '0;
    alu_op     = '0;
    alu_src    = 1'b0;
    md_en      = 1'b0;
    md_op      = '0;
    rd_ex      = '0;
    pc4_ex     = '0;
    read_data1 = '0;
    read_data2 = '0;
    imm        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1},
        '0);
    chk("reset_stall", stall, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_alu(4'd0, 32'd5, 32'hFFFF_FFFD, 1'b1, 5'h1C, 32'd2);
    run_md(3'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9);
    run_md(3'd1, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_md(3'd5, 32'd10, 32'd0, 32'hFFFF_FFFF);
    run_md(3'd7, 32'd10, 32'd0, 32'd10);
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

    // abandon a multiply mid-BUSY
    @(negedge clk);
    ctrl_ex    = 5'h1F;
    md_en      = 1'b1;
    md_op      = 3'd3;
    read_data1 = 32'h1234_5678;
    read_data2 = 32'h9ABC_DEF0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_stall_low", stall, 0);
    @(posedge clk);
    #1;
    chk("rst_mid_outs", {ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1},
        '0);
    chk("rst_mid_stall", stall, 0);
    @(negedge clk);
    md_en   = 1'b0;
    reset_n = 1'b1;

    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_alu(4'd7, 32'h8000_0000, 32'd4, 1'b1, 5'h03, 32'hF800_0000);

    for (int i = 0; i < 80; i++) begin
      a = pick();
      b = pick();
      if ($urandom_range(0, 2) == 0) begin
        mop = 3'($urandom);
        run_md(mop, a, b, ref_md(mop, a, b));
      end else begin
        aop = 4'($urandom_range(0, 11));
        src = 1'($urandom);
        c   = 5'($urandom);
        run_alu(aop, a, b, src, c, ref_alu(aop, a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32IM pipeline, sitting between the ID/EX inputs and the MEM stage. It computes single-cycle RV32I ALU results and runs multi-cycle M-extension multiply/divide with an iterative 32-step engine. While the engine runs, it stalls the upstream stages. Results land in the EX/MEM pipeline register that drives MEM's `ctrl_mem`, `rd_mem`, `pc4_mem`, `alu_result` and `write_data1` inputs.

## Interface
No parameters.

Reset is synchronous and active-low; `clk` and `reset_n` are the only clock and reset.

- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  synchronous active-low reset
- `ctrl_ex`  in  5  WB/MEM control bits, passed through to `ctrl_mem`
- `alu_op`  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; others give 0
- `alu_src`  in  1  operand B select: 1 = `imm`, 0 = `read_data2`
- `md_en`  in  1  current instruction is an M-extension op
- `md_op`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `rd_ex`  in  32  destination register field, passed through
- `pc4_ex`  in  32  PC+4, passed through
- `read_data1`  in  32  rs1 value
- `read_data2`  in  32  rs2 value
- `imm`  in  32  sign-extended immediate
- `ctrl_mem`  out  5  registered control to MEM
- `rd_mem`  out  32  registered destination
- `pc4_mem`  out  32  registered PC+4
- `alu_result`  out  32  registered ALU or M-op result
- `write_data1`  out  32  registered store data (= `read_data2`)
- `stall`  out  1  combinational; holds PC, IF/ID and ID/EX while high

## Operation
- Operand A is `read_data1`. Operand B is `imm` if `alu_src`, else `read_data2`.
- ALU ops:
  - Shifts use B[4:0].
  - SLT/SLTU return 0 or 1.
  - PASS_B returns B (used for LUI).
  - ADD/SUB wrap modulo 2^32.
- M-ops always use `read_data1` and `read_data2`, ignoring `alu_src`.
- FSM states IDLE, BUSY, DONE:
  - IDLE with `md_en`=1: latch operand magnitudes, operand signs and `md_op`; clear the step counter; go to BUSY.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After step 31 (counter==31), go to DONE.
  - DONE: apply the sign fix and special cases, present the result, go to IDLE unconditionally. `md_en` still high in DONE does not restart the engine.
- Multiply:
  - 64-bit unsigned product of magnitudes, negated if the operand signs differ.
  - MUL takes [31:0]. MULH, MULHSU and MULHU take [63:32].
  - Signedness: MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
- Divide:
  - Quotient sign is sign(a) XOR sign(b). Remainder sign is sign(a).
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed overflow (0x80000000 / -1): DIV gives 0x80000000, REM gives 0.
  - Special cases take the same latency as normal divides.
- `stall` = `reset_n` & ((state==IDLE & `md_en`) | state==BUSY).
- EX/MEM register update each edge:
  - `stall`=1: load a bubble. `ctrl_mem` <= 0; `rd_mem`, `pc4_mem`, `alu_result` and `write_data1` hold their values.
  - `stall`=0: load `ctrl_ex`, `rd_ex`, `pc4_ex`, `read_data2`, and the result. The result is the M result in DONE, otherwise the ALU result.
- Upstream holds all inputs stable while `stall`=1.

## Timing
- ALU ops: latency 1, with the result visible after the next rising edge. `stall` stays 0.
- M-ops: the instruction is present at cycle 0, when IDLE sees `md_en`.
  - `stall` is high in cycles 0 through 32, which is 33 cycles.
  - Cycle 33 is DONE; `stall` is low.
  - The result is registered at the edge ending cycle 33.
  - The next instruction is presented in cycle 34.
- Back-to-back M-ops: the second one sees IDLE and restarts immediately, with identical latency.
- Reset (`reset_n`=0 at an edge):
  - State goes to IDLE and the counter to 0.
  - All outputs and engine registers go to 0.
  - `stall` is 0 during any cycle with `reset_n` low.
  - Reset mid-BUSY abandons the operation. No partial result ever reaches `alu_result`.
- Output reset values: `ctrl_mem`, `rd_mem`, `pc4_mem`, `alu_result` and `write_data1` are all 0. `stall` is 0.

## Test plan
- ADD with `read_data1`=5, `imm`=0xFFFFFFFD, `alu_src`=1, `ctrl_ex`=0x1C → after one edge, `alu_result`=2 and `ctrl_mem`=0x1C; `stall` never rises.
- MUL and MULH of 0xFFFFFFFF × 7 → `stall` high exactly 33 cycles with `ctrl_mem`=0 during the stall. MUL gives 0xFFFFFFF9; MULH gives 0xFFFFFFFF.
- DIV and REM of 0xFFFFFFF9 (−7) and 2 → DIV gives 0xFFFFFFFD; REM gives 0xFFFFFFFF.
- Divide corner cases:
  - DIVU 10/0 gives 0xFFFFFFFF; REMU 10/0 gives 10.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
  - Each takes 33 stall cycles.
- Reset asserted in BUSY cycle 10 → all outputs 0 and `stall` 0 the next cycle. After release, re-issuing MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.
- MULHU immediately followed by SRA with A=0x80000000, B=4 → the MULHU result is 0xFFFFFFFE, and on the very next edge `alu_result`=0xF8000000 with `stall` 0.
